sram_like_arbiter: RTL
======================

# sram_like_arbiter

Parametrised N-to-1 arbiter for the sram-like bus protocol (req / addr_ok / data_ok) used between the pipeline and memory. It merges NCH sram-like master channels, such as the instruction fetch and data channels, onto one sram-like slave port. It supports round-robin or fixed-priority arbitration, stable grant locking while a request waits for addr_ok, and up to DEPTH outstanding transactions. Each in-order data_ok is routed back to the channel that issued the request. It sits between the CPU core and the single memory / AXI-bridge port.

## Interface
- NCH, default 2: number of master channels (≥1)
- AW, default 32: address width
- DW, default 32: data width (multiple of 8)
- DEPTH, default 4: maximum outstanding accepted-but-unanswered transactions (≥1)
- RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with channel 0 highest
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- m_req  in  NCH  per-channel request
- m_wr  in  NCH  per-channel write flag
- m_size  in  2*NCH  per-channel size (0 byte, 1 half, 2 word)
- m_wstrb  in  (DW/8)*NCH  per-channel byte strobes
- m_addr  in  AW*NCH  per-channel address
- m_wdata  in  DW*NCH  per-channel write data
- m_addr_ok  out  NCH  per-channel request accepted
- m_data_ok  out  NCH  per-channel response valid
- m_rdata  out  DW  read data, broadcast to all channels
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/DW/8/AW/DW  slave request fields
- s_addr_ok, s_data_ok  in  1  slave handshakes
- s_rdata  in  DW  slave read data
- err_spurious  out  1  sticky flag; set by s_data_ok while no transaction is outstanding

## Operation
- Grant selection:
  - RR_MODE=1: scan channels starting at rr_ptr+1 (mod NCH) and take the first with m_req=1.
  - RR_MODE=0: take the lowest index with m_req=1.
- Lock: if s_req=1 and s_addr_ok=0, set lock_valid=1 and lock_ch=grant. While locked, grant=lock_ch regardless of the other channels. Masters hold req and all fields stable until addr_ok.
- Lock clears on the cycle s_req && s_addr_ok.
- s_req = (grant exists) && (count < DEPTH) && !reset. When full, s_req stays 0 even if a pop happens in the same cycle. An existing lock is kept while full.
- s_* fields are muxed from the granted channel. When there is no grant, they are zero.
- m_addr_ok[i] = s_addr_ok && s_req && grant==i.
- Accept (s_req && s_addr_ok): push grant index into the ID FIFO; in RR_MODE=1, rr_ptr ← grant.
- s_data_ok with count>0: pop the FIFO head h; m_data_ok[h]=1; m_rdata=s_rdata always.
- s_data_ok with count==0: no m_data_ok, err_spurious ← 1 and stays set until reset.
- Simultaneous push and pop: count unchanged; the head advances and the new ID goes to the tail.
- The slave returns responses strictly in acceptance order; a response may arrive in the same cycle as a later acceptance.
- Widths: FIFO entry is max(1,$clog2(NCH)) bits. count is $clog2(DEPTH+1) bits. Pointers wrap modulo DEPTH.

## Timing
- Reset values, applied asynchronously: count=0, FIFO pointers 0, lock_valid=0, lock_ch=0, rr_ptr=NCH-1 (channel 0 wins first), err_spurious=0.
- During reset: s_req=0, m_addr_ok=0, m_data_ok=0, s_* fields 0.
- Zero-latency combinational paths: s_addr_ok → m_addr_ok, and s_data_ok → m_data_ok / m_rdata. The block adds no cycles.
- The FIFO, count, lock and rr_ptr update at the clock edge after the handshake.
- Reset asserted mid-transaction drops all outstanding IDs. Responses arriving after reset set err_spurious.

## Structure
- Shared package sram_like_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - a function for the channel-index width
- One sub-module, sram_like_id_fifo: parametrised synchronous FIFO (width, DEPTH) with push, pop, head, count and full outputs, and async active-high reset.
- Arbitration, lock and muxing live in the top module.

## Test plan
- **Reset defaults:** NCH=2, RR_MODE=1; both m_req=1, s_addr_ok=1 for 4 cycles → grants ch0, ch1, ch0, ch1; m_addr_ok alternates 01,10,01,10 (bit0 = ch0).
- **Lock:** ch1 req with s_addr_ok=0 for 3 cycles; ch0 raises req in cycle 2 → s_addr stays ch1's address; ch1 accepted in cycle 4; ch0 accepted in cycle 5.
- **Full stall:** DEPTH=4; accept 4 requests, no s_data_ok → s_req=0 in cycle 5. Pop one (s_data_ok=1) → s_req stays 0 that cycle and reasserts the next cycle.
- **Routing:** accept order ch0, ch1, ch1, ch0; return rdata 0x11,0x22,0x33,0x44 → m_data_ok hits ch0,ch1,ch1,ch0 with matching m_rdata.
- **Fixed priority:** RR_MODE=0, NCH=3; all requesting, s_addr_ok=1 → ch0 granted every cycle. Drop ch0 → ch1.
- **Spurious response and mid-operation reset:** s_data_ok with count=0 → err_spurious=1 and no m_data_ok. Assert reset with 2 outstanding → count=0, err_spurious cleared, s_req=0 immediately.

Source files
------------

// File: rtl/sram_like_pkg.sv
// ============================================================================
// Module   : sram_like_pkg
// Brief    : Shared encodings and helpers for the sram-like bus arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_id_fifo.sv
// ============================================================================
// Module   : sram_like_id_fifo
// Brief    : Synchronous FIFO of channel IDs for accepted, unanswered requests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_like_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (i_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : NCH-to-1 sram-like bus arbiter with grant lock and in-order routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH-1:0]        m_wr,
    input  logic [2*NCH-1:0]      m_size,
    input  logic [(DW/8)*NCH-1:0] m_wstrb,
    input  logic [AW*NCH-1:0]     m_addr,
    input  logic [DW*NCH-1:0]     m_wdata,
    output logic [NCH-1:0]        m_addr_ok,
    output logic [NCH-1:0]        m_data_ok,
    output logic [DW-1:0]         m_rdata,
    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [DW/8-1:0]       s_wstrb,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic                  s_addr_ok,
    input  logic                  s_data_ok,
    input  logic [DW-1:0]         s_rdata,
    output logic                  err_spurious
);

    localparam int IW = ch_idx_w(NCH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = DW / 8;

    logic          r_lock_valid;
    logic [IW-1:0] r_lock_ch;
    logic [IW-1:0] r_rr_ptr;
    logic          r_err_spurious;

    logic [IW-1:0] w_grant;
    logic          w_grant_valid;
    logic          w_sel;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic [IW-1:0] w_head;
    logic          w_push;
    logic          w_pop;

    // A locked request owns the port until the slave takes it.
    always_comb begin
        int idx;
        w_grant       = '0;
        w_grant_valid = 1'b0;
        idx           = 0;
        if (r_lock_valid) begin
            w_grant       = r_lock_ch;
            w_grant_valid = m_req[r_lock_ch];
        end else if (RR_MODE != 0) begin
            for (int k = 1; k <= NCH; k++) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (!w_grant_valid && m_req[idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = IW'(idx);
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (m_req[i]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = IW'(i);
                end
            end
        end
    end

    assign w_sel  = w_grant_valid && !reset;
    assign s_req  = w_sel && !w_full;
    assign w_push = s_req && s_addr_ok;
    assign w_pop  = s_data_ok && (w_count != '0);

    assign s_wr    = w_sel ? m_wr[w_grant]               : 1'b0;
    assign s_size  = w_sel ? m_size[w_grant*2 +: 2]      : 2'b00;
    assign s_wstrb = w_sel ? m_wstrb[w_grant*SW +: SW]   : '0;
    assign s_addr  = w_sel ? m_addr[w_grant*AW +: AW]    : '0;
    assign s_wdata = w_sel ? m_wdata[w_grant*DW +: DW]   : '0;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            m_addr_ok[i] = w_push && (w_grant == IW'(i));
            m_data_ok[i] = w_pop && (w_head == IW'(i));
        end
    end

    assign m_rdata      = s_rdata;
    assign err_spurious = r_err_spurious;

    sram_like_id_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_valid   <= 1'b0;
            r_lock_ch      <= '0;
            r_rr_ptr       <= IW'(NCH - 1);
            r_err_spurious <= 1'b0;
        end else begin
            if (w_push) begin
                r_lock_valid <= 1'b0;
            end else if (s_req) begin
                r_lock_valid <= 1'b1;
                r_lock_ch    <= w_grant;
            end
            if (w_push && (RR_MODE != 0)) begin
                r_rr_ptr <= w_grant;
            end
            if (s_data_ok && (w_count == '0)) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
